// File: rtl/chopper_timer_pair_pkg.sv
// Shared definitions for the dual-channel fixed-off-time chopper timer.
// Optional build macro: CHOPPER_STATS_EN (per-channel chop counters).
package chopper_timer_pair_pkg;

  localparam int OFF_W_DEF   = 10;
  localparam int BLANK_W_DEF = 8;
  localparam int PHASE_W     = 8;
  localparam int CHOP_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_OFF   = 2'd1,
    ST_BLANK = 2'd2
  } chop_state_e;

endpackage

// File: rtl/chopper_timer_pair_if.sv
// Bus between the microstepper control stage (master) and the chopper
// timer pair (slave). Optional build macro: CHOPPER_STATS_EN adds the
// stats_clear request and the two chop counters.
interface chopper_timer_pair_if
  import chopper_timer_pair_pkg::*;
#(
  parameter int OFF_W   = OFF_W_DEF,
  parameter int BLANK_W = BLANK_W_DEF
);
  logic [OFF_W-1:0]   config_offtime;
  logic [BLANK_W-1:0] config_blanktime;
  logic               offtimer_en0;
  logic               offtimer_en1;
  logic [PHASE_W-1:0] phase_ct;
  logic [OFF_W-1:0]   off_timer0;
  logic [OFF_W-1:0]   off_timer1;
  logic [BLANK_W-1:0] blank_timer0;
  logic [BLANK_W-1:0] blank_timer1;
  logic               off_timer0_done;
  logic               off_timer1_done;
`ifdef CHOPPER_STATS_EN
  logic                  stats_clear;
  logic [CHOP_CNT_W-1:0] chop_count0;
  logic [CHOP_CNT_W-1:0] chop_count1;
`endif

  modport master (
    output config_offtime, config_blanktime, offtimer_en0, offtimer_en1, phase_ct,
`ifdef CHOPPER_STATS_EN
    output stats_clear,
    input  chop_count0, chop_count1,
`endif
    input  off_timer0, off_timer1, blank_timer0, blank_timer1,
    input  off_timer0_done, off_timer1_done
  );

  modport slave (
    input  config_offtime, config_blanktime, offtimer_en0, offtimer_en1, phase_ct,
`ifdef CHOPPER_STATS_EN
    input  stats_clear,
    output chop_count0, chop_count1,
`endif
    output off_timer0, off_timer1, blank_timer0, blank_timer1,
    output off_timer0_done, off_timer1_done
  );

endinterface

// File: rtl/chopper_timer_pair_channel.sv
// One chopper channel: ARMED/OFF/BLANK FSM, off and blank timers, the
// off-period done strobe and (with CHOPPER_STATS_EN) a saturating chop counter.
module chopper_timer_channel
  import chopper_timer_pair_pkg::*;
#(
  parameter int OFF_W   = OFF_W_DEF,
  parameter int BLANK_W = BLANK_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OFF_W-1:0]      config_offtime,
  input  logic [BLANK_W-1:0]    config_blanktime,
  input  logic                  offtimer_en,
  input  logic                  commutate,
`ifdef CHOPPER_STATS_EN
  input  logic                  stats_clear,
  output logic [CHOP_CNT_W-1:0] chop_count,
`endif
  output logic [OFF_W-1:0]      off_timer,
  output logic [BLANK_W-1:0]    blank_timer,
  output logic                  off_timer_done
);

  chop_state_e        state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               done_q, done_d;
  logic               blank_nz;

  assign blank_nz = (config_blanktime != '0);

  // Next-state logic; the end of an off period (including a zero-length one)
  // pulses done and hands over to blanking, or straight to ARMED if blanking is 0.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (commutate) begin
          // Commutation beats a same-cycle off request.
          blank_d = config_blanktime;
          state_d = blank_nz ? ST_BLANK : ST_ARMED;
        end else if (offtimer_en) begin
          if (config_offtime != '0) begin
            off_d   = config_offtime;
            state_d = ST_OFF;
          end else begin
            done_d  = 1'b1;
            blank_d = config_blanktime;
            state_d = blank_nz ? ST_BLANK : ST_ARMED;
          end
        end
      end
      ST_OFF: begin
        if (off_q > OFF_W'(1)) begin
          off_d = off_q - OFF_W'(1);
        end else begin
          off_d   = '0;
          done_d  = 1'b1;
          blank_d = config_blanktime;
          state_d = blank_nz ? ST_BLANK : ST_ARMED;
        end
      end
      ST_BLANK: begin
        if (commutate) begin
          blank_d = config_blanktime;
          state_d = blank_nz ? ST_BLANK : ST_ARMED;
        end else if (blank_q > BLANK_W'(1)) begin
          blank_d = blank_q - BLANK_W'(1);
        end else begin
          blank_d = '0;
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
        off_d   = '0;
        blank_d = '0;
      end
    endcase
  end

  // State and timer registers; reset abandons any running timer without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARMED;
      off_q   <= '0;
      blank_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign off_timer      = off_q;
  assign blank_timer    = blank_q;
  assign off_timer_done = done_q;

`ifdef CHOPPER_STATS_EN
  logic [CHOP_CNT_W-1:0] cnt_q;

  // Count done pulses, saturating; a clear on the done cycle drops that pulse.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      cnt_q <= '0;
    end else if (done_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CHOP_CNT_W'(1);
    end
  end

  assign chop_count = cnt_q;
`endif

endmodule

// File: rtl/chopper_timer_pair.sv
// Dual fixed-off-time chopper timing stage (bridges A and B). Owns the
// shared phase_ct commutation detector and two independent channels.
// Optional build macro: CHOPPER_STATS_EN (adds stats_clear, chop_count0/1).
module chopper_timer_pair
  import chopper_timer_pair_pkg::*;
#(
  parameter int OFF_W   = OFF_W_DEF,
  parameter int BLANK_W = BLANK_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  chopper_timer_pair_if.slave  bus
);

  logic [PHASE_W-1:0] phase_q;
  logic               commutate;
  logic [1:0]         en_w;
  logic [1:0]         done_w;
  logic [OFF_W-1:0]   off_w   [2];
  logic [BLANK_W-1:0] blank_w [2];

  // Phase history; loaded with the live value in reset so reset exit is not a commutation.
  always_ff @(posedge clk) begin
    phase_q <= bus.phase_ct;
  end

  assign commutate = (bus.phase_ct != phase_q);
  assign en_w      = {bus.offtimer_en1, bus.offtimer_en0};

`ifdef CHOPPER_STATS_EN
  logic [CHOP_CNT_W-1:0] cnt_w [2];
  assign bus.chop_count0 = cnt_w[0];
  assign bus.chop_count1 = cnt_w[1];
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      chopper_timer_channel #(
        .OFF_W   (OFF_W),
        .BLANK_W (BLANK_W)
      ) u_ch (
        .clk              (clk),
        .reset            (reset),
        .config_offtime   (bus.config_offtime),
        .config_blanktime (bus.config_blanktime),
        .offtimer_en      (en_w[gi]),
        .commutate        (commutate),
`ifdef CHOPPER_STATS_EN
        .stats_clear      (bus.stats_clear),
        .chop_count       (cnt_w[gi]),
`endif
        .off_timer        (off_w[gi]),
        .blank_timer      (blank_w[gi]),
        .off_timer_done   (done_w[gi])
      );
    end
  endgenerate

  assign bus.off_timer0      = off_w[0];
  assign bus.off_timer1      = off_w[1];
  assign bus.blank_timer0    = blank_w[0];
  assign bus.blank_timer1    = blank_w[1];
  assign bus.off_timer0_done = done_w[0];
  assign bus.off_timer1_done = done_w[1];

endmodule

// File: tb/tb_chopper_timer_pair.sv
// Testbench for chopper_timer_pair: behavioural model checked every cycle,
// literal expectations for the directed scenarios, then random stimulus.
module tb_chopper_timer_pair;

  logic clk = 1'b0;
  logic reset;

  chopper_timer_pair_if bus_if ();

  chopper_timer_pair dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining off/blank counts per channel; the mode is implied by
  // which count is nonzero (off > 0 means off period, blank > 0 means blanking).
  int m_off   [2];
  int m_blank [2];
  int m_done  [2];
  int m_cnt   [2];
  int m_prev_phase;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_step();
    int en [2];
    bit comm;
    en[0] = bus_if.offtimer_en0;
    en[1] = bus_if.offtimer_en1;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_off[c] = 0; m_blank[c] = 0; m_done[c] = 0; m_cnt[c] = 0;
      end
      m_prev_phase = bus_if.phase_ct;
      return;
    end
    comm = (bus_if.phase_ct != m_prev_phase);
    m_prev_phase = bus_if.phase_ct;
    for (int c = 0; c < 2; c++) begin
`ifdef CHOPPER_STATS_EN
      if (bus_if.stats_clear) m_cnt[c] = 0;
      else if (m_done[c] != 0 && m_cnt[c] < 65535) m_cnt[c]++;
`endif
      m_done[c] = 0;
      if (m_off[c] > 0) begin
        m_off[c]--;
        if (m_off[c] == 0) begin
          m_done[c]  = 1;
          m_blank[c] = bus_if.config_blanktime;
        end
      end else if (comm) begin
        m_blank[c] = bus_if.config_blanktime;
      end else if (m_blank[c] > 0) begin
        m_blank[c]--;
      end else if (en[c] != 0) begin
        if (bus_if.config_offtime != 0) m_off[c] = bus_if.config_offtime;
        else begin
          m_done[c]  = 1;
          m_blank[c] = bus_if.config_blanktime;
        end
      end
    end
  endfunction

  task automatic compare();
    check("off_timer0",   bus_if.off_timer0,      m_off[0]);
    check("off_timer1",   bus_if.off_timer1,      m_off[1]);
    check("blank_timer0", bus_if.blank_timer0,    m_blank[0]);
    check("blank_timer1", bus_if.blank_timer1,    m_blank[1]);
    check("done0",        bus_if.off_timer0_done, m_done[0]);
    check("done1",        bus_if.off_timer1_done, m_done[1]);
`ifdef CHOPPER_STATS_EN
    check("chop_count0",  bus_if.chop_count0,     m_cnt[0]);
    check("chop_count1",  bus_if.chop_count1,     m_cnt[1]);
`endif
  endtask

  // One clock: inputs are already stable, model steps on the edge, outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_off   [9] = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
  int exp_done  [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int exp_blank [9] = '{0, 0, 0, 0, 0, 3, 2, 1, 0};

  initial begin
    int nz;
    int dn;
    reset = 1'b1;
    bus_if.config_offtime   = '0;
    bus_if.config_blanktime = '0;
    bus_if.offtimer_en0     = 1'b0;
    bus_if.offtimer_en1     = 1'b0;
    bus_if.phase_ct         = 8'h3C;
`ifdef CHOPPER_STATS_EN
    bus_if.stats_clear      = 1'b0;
`endif
    idle(3);
    // Reset state
    check("reset_off0", bus_if.off_timer0, 0);
    check("reset_blank1", bus_if.blank_timer1, 0);
    check("reset_done0", bus_if.off_timer0_done, 0);
    reset = 1'b0;
    idle(3);
    check("no_comm_at_reset_exit", bus_if.blank_timer0, 0);

    // Basic cycle: offtime 5, blanktime 3
    bus_if.config_offtime   = 10'd5;
    bus_if.config_blanktime = 8'd3;
    bus_if.offtimer_en0     = 1'b1;
    tick();
    bus_if.offtimer_en0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      check($sformatf("basic_off0[%0d]", k), bus_if.off_timer0, exp_off[k]);
      check($sformatf("basic_done0[%0d]", k), bus_if.off_timer0_done, exp_done[k]);
      check($sformatf("basic_blank0[%0d]", k), bus_if.blank_timer0, exp_blank[k]);
      check($sformatf("basic_chB_idle[%0d]", k), bus_if.off_timer1 + bus_if.blank_timer1, 0);
    end
    bus_if.offtimer_en0 = 1'b1;
    tick();
    bus_if.offtimer_en0 = 1'b0;
    check("basic_rearmed", bus_if.off_timer0, 5);
    idle(12);

    // Zero config on channel B
    bus_if.config_offtime   = 10'd0;
    bus_if.config_blanktime = 8'd0;
    bus_if.offtimer_en1     = 1'b1;
    tick();
    bus_if.offtimer_en1 = 1'b0;
    check("zero_done1", bus_if.off_timer1_done, 1);
    check("zero_off1", bus_if.off_timer1, 0);
    check("zero_blank1", bus_if.blank_timer1, 0);
    tick();
    check("zero_done1_clear", bus_if.off_timer1_done, 0);
    check("zero_blank1_after", bus_if.blank_timer1, 0);

    // Commutation beats en0 while ARMED
    bus_if.config_offtime   = 10'd5;
    bus_if.config_blanktime = 8'd4;
    bus_if.phase_ct = 8'h10;
    idle(8);
    bus_if.phase_ct     = 8'h11;
    bus_if.offtimer_en0 = 1'b1;
    tick();
    bus_if.offtimer_en0 = 1'b0;
    check("comm_blank0", bus_if.blank_timer0, 4);
    check("comm_blank1", bus_if.blank_timer1, 4);
    check("comm_off0", bus_if.off_timer0, 0);
    idle(6);

    // en0 held high, phase change during OFF: period length stays 7
    bus_if.config_offtime   = 10'd7;
    bus_if.config_blanktime = 8'd2;
    bus_if.offtimer_en0     = 1'b1;
    nz = 0; dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus_if.phase_ct = 8'h55;
      tick();
      if (bus_if.off_timer0 != 0) nz++;
      if (bus_if.off_timer0_done) dn++;
    end
    bus_if.offtimer_en0 = 1'b0;
    check("ignored_off_len", nz, 7);
    check("ignored_done_cnt", dn, 1);
    idle(20);

    // Reset mid-off with off_timer0 = 300
    bus_if.config_offtime   = 10'd300;
    bus_if.config_blanktime = 8'd3;
    bus_if.offtimer_en0     = 1'b1;
    tick();
    bus_if.offtimer_en0 = 1'b0;
    check("rst_mid_loaded", bus_if.off_timer0, 300);
    reset = 1'b1;
    tick();
    check("rst_mid_off0", bus_if.off_timer0, 0);
    check("rst_mid_blank0", bus_if.blank_timer0, 0);
    check("rst_mid_done0", bus_if.off_timer0_done, 0);
    reset = 1'b0;
    tick();
    bus_if.offtimer_en0 = 1'b1;
    tick();
    bus_if.offtimer_en0 = 1'b0;
    nz = (bus_if.off_timer0 != 0) ? 1 : 0;
    dn = 0;
    for (int i = 0; i < 305; i++) begin
      tick();
      if (bus_if.off_timer0 != 0) nz++;
      if (bus_if.off_timer0_done) dn++;
    end
    check("rst_fresh_off_len", nz, 300);
    check("rst_fresh_done_cnt", dn, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus_if.offtimer_en0 = ($urandom_range(0, 3) == 0);
      bus_if.offtimer_en1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus_if.phase_ct = 8'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        bus_if.config_offtime   = 10'($urandom_range(0, 12));
        bus_if.config_blanktime = 8'($urandom_range(0, 6));
      end
`ifdef CHOPPER_STATS_EN
      bus_if.stats_clear = ($urandom_range(0, 199) == 0);
`endif
      tick();
    end
    reset = 1'b0;
    bus_if.offtimer_en0 = 1'b0;
    bus_if.offtimer_en1 = 1'b0;
    idle(20);

`ifdef CHOPPER_STATS_EN
    // Saturation: zero-length off periods give a done pulse every cycle
    bus_if.stats_clear = 1'b1;
    tick();
    bus_if.stats_clear      = 1'b0;
    bus_if.config_offtime   = 10'd0;
    bus_if.config_blanktime = 8'd0;
    bus_if.offtimer_en0     = 1'b1;
    idle(65540);
    check("stats_saturated", bus_if.chop_count0, 16'hFFFF);
    check("stats_done_cycle", bus_if.off_timer0_done, 1);
    bus_if.stats_clear = 1'b1;
    tick();
    bus_if.stats_clear = 1'b0;
    check("stats_clear_wins", bus_if.chop_count0, 0);
    tick();
    check("stats_after_clear", bus_if.chop_count0, 1);
    bus_if.offtimer_en0 = 1'b0;
    idle(4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
